// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite attribute scheduler: walks all 128 sprite entries on each
// line strobe and streams one record per visible sprite over valid/ready.
module sprite_line_scanner #(
    parameter int MAX_HITS = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_i,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        spr_valid_o,
    input  logic        spr_ready_i,
    output logic [11:0] spr_addr_o,
    output logic        spr_mode_o,
    output logic [9:0]  spr_x_o,
    output logic        spr_hflip_o,
    output logic [1:0]  spr_z_o,
    output logic [3:0]  spr_coll_o,
    output logic [3:0]  spr_pal_o,
    output logic [1:0]  spr_width_o,
    output logic [5:0]  spr_row_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o
);

    typedef enum logic [2:0] {IDLE, FETCH1, EVAL, CAP, OUT, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  line_q, line_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  hits_q, hits_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic [11:0] addr_q, addr_d;
    logic        mode_q, mode_d;
    logic [9:0]  x_q, x_d;
    logic        hflip_q, hflip_d;
    logic [1:0]  z_q, z_d;
    logic [3:0]  coll_q, coll_d;
    logic [3:0]  pal_q, pal_d;
    logic [1:0]  width_q, width_d;
    logic [5:0]  row_q, row_d;

    logic [6:0]  height;
    logic [9:0]  diff;
    logic [5:0]  row_calc;
    logic        hit, last, hs, cap_full;
    logic        unused_bits;

    // rd_data_i carries word1 during EVAL; vflip lives in word1[17]
    assign height   = 7'd8 << rd_data_i[31:30];
    assign diff     = line_q - rd_data_i[9:0];
    assign hit      = (rd_data_i[19:18] != 2'd0) && (diff < {3'b000, height});
    assign row_calc = rd_data_i[17] ? (height[5:0] - 6'd1 - diff[5:0]) : diff[5:0];
    assign last     = (idx_q == 7'd127);
    assign hs       = valid_q && spr_ready_i;
    assign cap_full = ((hits_q + 8'd1) == 8'(MAX_HITS)) && !last;
    assign unused_bits = ^{rd_data_i[15:10]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_start_i) state_d = FETCH1;
            FETCH1:  state_d = EVAL;
            EVAL:    state_d = hit ? CAP : (last ? DONE : FETCH1);
            CAP:     state_d = OUT;
            OUT:     if (hs) state_d = (cap_full || last) ? DONE : FETCH1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a new strobe restarts the scan from any state
        if (line_start_i) state_d = FETCH1;
    end

    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = rd_addr_q;
        if (state_q == FETCH1) begin
            rd_en_o   = 1'b1;
            rd_addr_o = {idx_q, 1'b1};
        end else if (state_q == EVAL && hit) begin
            rd_en_o   = 1'b1;
            rd_addr_o = {idx_q, 1'b0};
        end
        busy_o = (state_q != IDLE);
    end

    always_comb begin
        line_d    = line_q;
        idx_d     = idx_q;
        hits_d    = hits_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        rd_addr_d = rd_addr_o;
        addr_d    = addr_q;
        mode_d    = mode_q;
        x_d       = x_q;
        hflip_d   = hflip_q;
        z_d       = z_q;
        coll_d    = coll_q;
        pal_d     = pal_q;
        width_d   = width_q;
        row_d     = row_q;
        done_d    = (state_q == DONE);
        if (line_start_i) begin
            line_d  = line_i;
            idx_d   = 7'd0;
            hits_d  = 8'd0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                EVAL: begin
                    if (hit) begin
                        hflip_d = rd_data_i[16];
                        z_d     = rd_data_i[19:18];
                        coll_d  = rd_data_i[23:20];
                        pal_d   = rd_data_i[27:24];
                        width_d = rd_data_i[29:28];
                        row_d   = row_calc;
                    end else if (!last) begin
                        idx_d = idx_q + 7'd1;
                    end
                end
                CAP: begin
                    addr_d  = rd_data_i[11:0];
                    mode_d  = rd_data_i[15];
                    x_d     = rd_data_i[25:16];
                    valid_d = 1'b1;
                end
                OUT: begin
                    if (hs) begin
                        valid_d = 1'b0;
                        hits_d  = hits_q + 8'd1;
                        if (cap_full)   ovf_d = 1'b1;
                        else if (!last) idx_d = idx_q + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_q    <= '0;
            idx_q     <= '0;
            hits_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            rd_addr_q <= '0;
            addr_q    <= '0;
            mode_q    <= 1'b0;
            x_q       <= '0;
            hflip_q   <= 1'b0;
            z_q       <= '0;
            coll_q    <= '0;
            pal_q     <= '0;
            width_q   <= '0;
            row_q     <= '0;
        end else begin
            line_q    <= line_d;
            idx_q     <= idx_d;
            hits_q    <= hits_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            x_q       <= x_d;
            hflip_q   <= hflip_d;
            z_q       <= z_d;
            coll_q    <= coll_d;
            pal_q     <= pal_d;
            width_q   <= width_d;
            row_q     <= row_d;
        end
    end

    assign spr_valid_o = valid_q;
    assign spr_addr_o  = addr_q;
    assign spr_mode_o  = mode_q;
    assign spr_x_o     = x_q;
    assign spr_hflip_o = hflip_q;
    assign spr_z_o     = z_q;
    assign spr_coll_o  = coll_q;
    assign spr_pal_o   = pal_q;
    assign spr_width_o = width_q;
    assign spr_row_o   = row_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner with a behavioural 256x32 sprite RAM.
module tb_sprite_line_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line = '0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        spr_valid;
    logic        spr_ready = 1'b1;
    logic [11:0] spr_addr;
    logic        spr_mode;
    logic [9:0]  spr_x;
    logic        spr_hflip;
    logic [1:0]  spr_z;
    logic [3:0]  spr_coll;
    logic [3:0]  spr_pal;
    logic [1:0]  spr_width;
    logic [5:0]  spr_row;
    logic        busy, done, overflow;

    sprite_line_scanner #(.MAX_HITS(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .line_start_i(line_start), .line_i(line),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .spr_valid_o(spr_valid), .spr_ready_i(spr_ready),
        .spr_addr_o(spr_addr), .spr_mode_o(spr_mode), .spr_x_o(spr_x),
        .spr_hflip_o(spr_hflip), .spr_z_o(spr_z), .spr_coll_o(spr_coll),
        .spr_pal_o(spr_pal), .spr_width_o(spr_width), .spr_row_o(spr_row),
        .busy_o(busy), .done_o(done), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [11:0] addr; logic mode; logic [9:0] x; logic hflip; logic [1:0] z;
        logic [3:0] coll; logic [3:0] pal; logic [1:0] width; logic [5:0] row;
    } rec_t;

    rec_t recs[$];
    int   since, reads, done_at, done_cnt, first_vld;
    int   n_chk = 0, n_pass = 0;

    // per-scan bookkeeping; everything restarts on a strobe
    always @(negedge clk) begin
        if (line_start) begin
            since = 0; reads = 0; done_at = -1; done_cnt = 0; first_vld = -1;
            recs.delete();
        end else begin
            since++;
            if (rd_en) reads++;
            if (done) begin done_cnt++; done_at = since; end
            if (spr_valid && first_vld < 0) first_vld = since;
            if (spr_valid && spr_ready)
                recs.push_back('{spr_addr, spr_mode, spr_x, spr_hflip, spr_z,
                                 spr_coll, spr_pal, spr_width, spr_row});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clr_mem;
        for (int k = 0; k < 256; k++) mem[k] = '0;
    endtask

    task automatic set_spr(input int i, input logic [31:0] w0, input logic [31:0] w1);
        mem[2*i] = w0; mem[2*i+1] = w1;
    endtask

    task automatic start(input logic [9:0] ln);
        line = ln; line_start = 1'b1;
        tick;
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 600) begin tick; n++; end
        if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
        tick;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!spr_valid && n < 100) begin tick; n++; end
        if (!spr_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    int          unstable, rb;
    logic [27:0] snap;

    initial begin
        clr_mem;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_valid", spr_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);

        // all disabled
        start(10'd5);
        chk("first_rd_en", rd_en, 1);
        chk("first_rd_addr", rd_addr, 8'h01);
        wait_done("allmiss");
        chk("allmiss_done_at", done_at, 258);
        chk("allmiss_done_cnt", done_cnt, 1);
        chk("allmiss_reads", reads, 128);
        chk("allmiss_recs", recs.size(), 0);
        chk("allmiss_ovf", overflow, 0);
        chk("allmiss_busy", busy, 0);

        // sprite 3: y=10, height 16, z=1, full field set
        set_spr(3, 32'h003C_8100, 32'h6535_000A);
        start(10'd17);
        wait_done("spr3");
        chk("spr3_recs", recs.size(), 1);
        if (recs.size() == 1) begin
            chk("spr3_x", recs[0].x, 60);
            chk("spr3_addr", recs[0].addr, 12'h100);
            chk("spr3_mode", recs[0].mode, 1);
            chk("spr3_row", recs[0].row, 7);
            chk("spr3_hflip", recs[0].hflip, 1);
            chk("spr3_z", recs[0].z, 1);
            chk("spr3_coll", recs[0].coll, 3);
            chk("spr3_pal", recs[0].pal, 5);
            chk("spr3_width", recs[0].width, 2);
        end
        start(10'd26);
        wait_done("spr3_l26");
        chk("spr3_l26_recs", recs.size(), 0);

        // vflip
        set_spr(3, 32'h003C_8100, 32'h6537_000A);
        start(10'd10);
        wait_done("vflip");
        chk("vflip_recs", recs.size(), 1);
        if (recs.size() == 1) chk("vflip_row", recs[0].row, 15);

        // y wraps past 1023
        set_spr(3, 32'h0005_0000, 32'h0004_03FC);
        start(10'd3);
        wait_done("wrap");
        chk("wrap_recs", recs.size(), 1);
        if (recs.size() == 1) begin
            chk("wrap_row", recs[0].row, 7);
            chk("wrap_x", recs[0].x, 5);
        end

        // ten hits against MAX_HITS=4
        clr_mem;
        for (int i = 0; i < 10; i++) set_spr(i, {6'd0, 10'(i), 16'h0000}, 32'h0004_0014);
        start(10'd20);
        wait_done("ovf");
        chk("ovf_first_vld", first_vld, 4);
        chk("ovf_recs", recs.size(), 4);
        for (int i = 0; i < 4 && i < recs.size(); i++) chk($sformatf("ovf_x%0d", i), recs[i].x, i);
        chk("ovf_flag", overflow, 1);
        chk("ovf_done_cnt", done_cnt, 1);

        // renderer stall
        clr_mem;
        set_spr(3, 32'h003C_8100, 32'h6535_000A);
        spr_ready = 1'b0;
        start(10'd17);
        chk("stall_ovf_clr", overflow, 0);
        wait_valid("stall");
        snap = {spr_x, spr_addr, spr_row};
        rb = reads;
        unstable = 0;
        repeat (20) begin
            tick;
            if ({spr_x, spr_addr, spr_row} !== snap || !spr_valid) unstable++;
        end
        chk("stall_stable", unstable, 0);
        chk("stall_noread", reads - rb, 0);
        chk("stall_norec", recs.size(), 0);
        spr_ready = 1'b1;
        tick;
        chk("stall_release_valid", spr_valid, 0);
        wait_done("stall");
        chk("stall_recs", recs.size(), 1);

        // abort while holding a record
        set_spr(7, 32'h004D_0000, 32'h0008_0064);
        spr_ready = 1'b0;
        start(10'd17);
        wait_valid("abort");
        chk("abort_pending_x", spr_x, 60);
        line = 10'd100; line_start = 1'b1; spr_ready = 1'b1;
        tick;
        line_start = 1'b0;
        chk("abort_valid_drop", spr_valid, 0);
        chk("abort_rd_en", rd_en, 1);
        chk("abort_rd_addr", rd_addr, 8'h01);
        wait_done("abort");
        chk("abort_recs", recs.size(), 1);
        if (recs.size() == 1) begin
            chk("abort_x", recs[0].x, 77);
            chk("abort_row", recs[0].row, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
